// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad configuration serial loader.
package gpio_cfg_pkg;

    localparam int CFG_BITS = 13;
    localparam logic [CFG_BITS-1:0] DEFAULT_CFG = 13'h0403;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LOAD     = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/gpio_cfg_serial_loader_timer.sv
// gpio_cfg_bit_timer: phase counter that pulses phase_end on the last cycle of each CLK_DIV-cycle phase.
module gpio_cfg_bit_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic en,
    output logic phase_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign phase_end = en && (cnt == LAST);

    // Phases run back to back while enabled, so the count restarts on phase_end.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt <= '0;
        end else if (!en || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/gpio_cfg_serial_loader.sv
// Pad configuration word store plus serial shift-chain loader (serial_clock/serial_data/serial_load).
// Optional chain readback capture is built when GPIO_CFG_READBACK_EN is defined.
//
// state    | meaning
// IDLE     | waiting for load_req; register writes accepted
// SHIFT_LO | serial_clock low, current bit presented on serial_data
// SHIFT_HI | serial_clock high, serial_data held
// LOAD     | serial_load strobe, chain transfers into pad registers
// DONE     | one-cycle completion pulse
module gpio_cfg_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS = 38,
    parameter int CLK_DIV  = 2,
    localparam int AW      = $clog2(NUM_PADS)
) (
    input  logic                clock,
    input  logic                resetb,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wdata,
    output logic [CFG_BITS-1:0] cfg_rdata,
    input  logic                load_req,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    input  logic                serial_data_ret,
    output logic [CFG_BITS-1:0] rb_rdata
);

    localparam int NB = NUM_PADS * CFG_BITS;
    localparam int BW = $clog2(CFG_BITS);

    state_e state, state_nx;

    logic [CFG_BITS-1:0] cfg_mem [NUM_PADS];
    logic [AW-1:0]       word_idx;
    logic [BW-1:0]       bit_pos;
    logic                phase_end;
    logic                timer_en;
    logic                addr_ok;
    logic                last_bit;
    logic                shift_step;
    logic                cur_bit;

    assign addr_ok    = {1'b0, cfg_addr} < (AW + 1)'(NUM_PADS);
    assign last_bit   = (word_idx == '0) && (bit_pos == '0);
    assign shift_step = (state == SHIFT_HI) && phase_end;
    assign cur_bit    = cfg_mem[word_idx][bit_pos];
    assign timer_en   = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LOAD);
    assign cfg_rdata  = addr_ok ? cfg_mem[cfg_addr] : '0;

    gpio_cfg_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clock     (clock),
        .resetb    (resetb),
        .en        (timer_en),
        .phase_end (phase_end)
    );

    // The array is frozen for the whole shift so serial_data can read it live.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                cfg_mem[i] <= DEFAULT_CFG;
            end
        end else if (cfg_we && addr_ok && !timer_en) begin
            cfg_mem[cfg_addr] <= cfg_wdata;
        end
    end

    // Bit pointer walks word NUM_PADS-1 MSB down to word 0 LSB.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            word_idx <= AW'(NUM_PADS - 1);
            bit_pos  <= BW'(CFG_BITS - 1);
        end else if ((state == IDLE) && load_req) begin
            word_idx <= AW'(NUM_PADS - 1);
            bit_pos  <= BW'(CFG_BITS - 1);
        end else if (shift_step && !last_bit) begin
            if (bit_pos == '0) begin
                bit_pos  <= BW'(CFG_BITS - 1);
                word_idx <= word_idx - AW'(1);
            end else begin
                bit_pos <= bit_pos - BW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        done         = 1'b0;
        serial_clock = 1'b0;
        serial_data  = 1'b0;
        serial_load  = 1'b0;
        case (state)
            IDLE: begin
                if (load_req) begin
                    state_nx = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                busy        = 1'b1;
                serial_data = cur_bit;
                if (phase_end) begin
                    state_nx = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                busy         = 1'b1;
                serial_clock = 1'b1;
                serial_data  = cur_bit;
                if (phase_end) begin
                    state_nx = last_bit ? LOAD : SHIFT_LO;
                end
            end
            LOAD: begin
                busy        = 1'b1;
                serial_load = 1'b1;
                if (phase_end) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef GPIO_CFG_READBACK_EN
    // Returned bits arrive in outgoing order, so the flat vector is {word NUM_PADS-1, ..., word 0}.
    logic [NB-1:0] rb_shift;
    logic [NB-1:0] rb_word;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rb_shift <= '0;
            rb_word  <= '0;
        end else begin
            if (shift_step) begin
                rb_shift <= {rb_shift[NB-2:0], serial_data_ret};
            end
            if (state == DONE) begin
                rb_word <= rb_shift;
            end
        end
    end

    assign rb_rdata = addr_ok ? rb_word[int'(cfg_addr) * CFG_BITS +: CFG_BITS] : '0;
`else
    logic unused_ret;
    assign unused_ret = serial_data_ret;
    assign rb_rdata   = '0;
`endif

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Directed self-checking bench for gpio_cfg_serial_loader (NUM_PADS=38, CFG_BITS=13, CLK_DIV=2).
module tb_gpio_cfg_serial_loader;

    localparam int NP = 38;
    localparam int CB = 13;
    localparam int NB = NP * CB;
    localparam int BUSY_CYC = 2 * 2 * NB + 2;

    logic          clock = 1'b0;
    logic          resetb = 1'b0;
    logic          cfg_we = 1'b0;
    logic [5:0]    cfg_addr = '0;
    logic [CB-1:0] cfg_wdata = '0;
    logic [CB-1:0] cfg_rdata;
    logic          load_req = 1'b0;
    logic          busy, done, serial_clock, serial_data, serial_load;
    logic          serial_data_ret;
    logic [CB-1:0] rb_rdata;

    gpio_cfg_serial_loader #(.NUM_PADS(NP), .CLK_DIV(2)) dut (
        .clock           (clock),
        .resetb          (resetb),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .cfg_rdata       (cfg_rdata),
        .load_req        (load_req),
        .busy            (busy),
        .done            (done),
        .serial_clock    (serial_clock),
        .serial_data     (serial_data),
        .serial_load     (serial_load),
        .serial_data_ret (serial_data_ret),
        .rb_rdata        (rb_rdata)
    );

    always #5 clock = ~clock;

    // Loopback chain: the returned bit is the one pushed out of the tail by each shift.
    logic [NB-1:0] chain = '0;
    logic          ret_q = 1'b0;
    always @(posedge serial_clock) begin
        ret_q <= chain[NB-1];
        chain <= {chain[NB-2:0], serial_data};
    end
    assign serial_data_ret = ret_q;

    int n_cmp = 0;
    int n_mis = 0;

    logic [CB-1:0] model [NP];
    logic [CB-1:0] a_words [NP];

    int            r_busy, r_rises, r_load_cyc, r_load_pulses, r_done_cyc, r_hold, r_timeout;
    logic [NB-1:0] r_bits;

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] stream();
        logic [NB-1:0] s;
        for (int k = 0; k < NP; k++) s[k*CB +: CB] = model[k];
        return s;
    endfunction

    task automatic rd(input int a);
        cfg_addr = a[5:0];
        #1;
    endtask

    task automatic wr(input int a, input logic [CB-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a[5:0];
        cfg_wdata = d;
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    // Caller has already raised load_req (and possibly cfg_we) just after a negedge.
    task automatic run_load(input int inj);
        logic prev_sc, prev_sd, prev_sl;
        int   post;
        bit   seen;
        r_busy = 0; r_rises = 0; r_load_cyc = 0; r_load_pulses = 0;
        r_done_cyc = 0; r_hold = 0; r_timeout = 1; r_bits = '0;
        prev_sc = 1'b0; prev_sd = 1'b0; prev_sl = 1'b0; post = 0; seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (c == 0) begin
                load_req = 1'b0;
                cfg_we   = 1'b0;
            end
            if (c == inj) begin
                cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 13'h0AAA; load_req = 1'b1;
            end else if (c == inj + 1) begin
                cfg_we = 1'b0; load_req = 1'b0;
            end
            if (busy) r_busy++;
            if (serial_clock && !prev_sc) begin
                if (r_rises < NB) r_bits[NB-1-r_rises] = serial_data;
                r_rises++;
            end
            if (serial_clock && prev_sc && (serial_data !== prev_sd)) r_hold++;
            if (serial_load) r_load_cyc++;
            if (serial_load && !prev_sl) r_load_pulses++;
            if (done) begin
                r_done_cyc++;
                seen = 1'b1;
            end
            if (seen) post++;
            prev_sc = serial_clock; prev_sd = serial_data; prev_sl = serial_load;
            if (post == 20) begin
                r_timeout = 0;
                break;
            end
        end
    endtask

    task automatic chk_load(input string tag);
        chk({tag, "_timeout"}, NB'(r_timeout), '0);
        chk({tag, "_busy"}, NB'(r_busy), NB'(BUSY_CYC));
        chk({tag, "_rises"}, NB'(r_rises), NB'(NB));
        chk({tag, "_load_cyc"}, NB'(r_load_cyc), NB'(2));
        chk({tag, "_load_pulses"}, NB'(r_load_pulses), NB'(1));
        chk({tag, "_done_cyc"}, NB'(r_done_cyc), NB'(1));
        chk({tag, "_hold"}, NB'(r_hold), '0);
        chk({tag, "_bits"}, r_bits, stream());
    endtask

    initial begin
        int            to, sl, rises;
        logic          prev;
        logic [CB-1:0] w;

        for (int k = 0; k < NP; k++) model[k] = 13'h0403;
        #2;
        chk("rst_outs_async", NB'({busy, done, serial_clock, serial_data, serial_load}), '0);
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);

        // 1: defaults everywhere, out-of-range reads return 0
        chk("t1_outs", NB'({busy, done, serial_clock, serial_data, serial_load}), '0);
        for (int a = 0; a < 64; a++) begin
            rd(a);
            chk($sformatf("t1_rdata_%0d", a), NB'(cfg_rdata), NB'((a < NP) ? 13'h0403 : 13'h0000));
        end
        chk("t1_rb", NB'(rb_rdata), '0);

        // 2: basic load
        @(negedge clock);
        wr(37, 13'h1FFF); model[37] = 13'h1FFF;
        wr(0, 13'h0001);  model[0]  = 13'h0001;
        wr(45, 13'h0777);
        load_req = 1'b1;
        run_load(-1);
        chk_load("t2");
        chk("t2_first13", NB'(r_bits[NB-1 -: CB]), NB'(13'h1FFF));
        chk("t2_last", NB'(r_bits[0]), NB'(1'b1));
        chk("t2_pad0_hi", NB'(r_bits[12:1]), '0);
`ifndef GPIO_CFG_READBACK_EN
        rd(37);
        chk("t2_rb_zero", NB'(rb_rdata), '0);
`endif

        // 3: write and load_req during busy are dropped
        load_req = 1'b1;
        run_load(100);
        chk_load("t3");
        rd(5);
        chk("t3_pad5", NB'(cfg_rdata), NB'(13'h0403));

        // 4: write and load_req in the same idle cycle
        cfg_we = 1'b1; cfg_addr = 6'd37; cfg_wdata = 13'h0000; load_req = 1'b1;
        model[37] = 13'h0000;
        run_load(-1);
        chk_load("t4");
        chk("t4_first13", NB'(r_bits[NB-1 -: CB]), '0);

        // 5: reset mid-load
        load_req = 1'b1; to = 1; sl = 0; rises = 0; prev = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (c == 0) load_req = 1'b0;
            if (serial_load) sl++;
            if (serial_clock && !prev) rises++;
            prev = serial_clock;
            if (rises == 200) begin
                to = 0;
                break;
            end
        end
        chk("t5_timeout", NB'(to), '0);
        chk("t5_busy_before", NB'(busy), NB'(1'b1));
        #2 resetb = 1'b0;
        #1;
        chk("t5_outs_async", NB'({busy, done, serial_clock, serial_data, serial_load}), '0);
        chk("t5_no_load", NB'(sl), '0);
        repeat (2) @(negedge clock);
        chk("t5_outs_held", NB'({busy, done, serial_clock, serial_data, serial_load}), '0);
        resetb = 1'b1;
        for (int k = 0; k < NP; k++) model[k] = 13'h0403;
        @(negedge clock);
        rd(37);
        chk("t5_pad37", NB'(cfg_rdata), NB'(13'h0403));
        rd(0);
        chk("t5_pad0", NB'(cfg_rdata), NB'(13'h0403));
        chk("t5_idle", NB'({busy, done, serial_load}), '0);

`ifdef GPIO_CFG_READBACK_EN
        // 6: load A then B through the loopback; readback shows A
        @(negedge clock);
        for (int k = 0; k < NP; k++) begin
            w = 13'((k * 331 + 77) ^ 13'h1555);
            a_words[k] = w;
            model[k] = w;
            wr(k, w);
        end
        load_req = 1'b1;
        run_load(-1);
        chk_load("t6a");
        for (int k = 0; k < NP; k++) begin
            w = ~a_words[k] ^ 13'(k);
            model[k] = w;
            wr(k, w);
        end
        load_req = 1'b1;
        run_load(-1);
        chk_load("t6b");
        for (int k = 0; k < NP; k++) begin
            rd(k);
            chk($sformatf("t6_rb_%0d", k), NB'(rb_rdata), NB'(a_words[k]));
        end
        rd(50);
        chk("t6_rb_oor", NB'(rb_rdata), '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
